// File: rtl/s27_array_misr.sv
// Array of CH s27 benchmark cores with a full scan chain and a MISR that compacts G17.
// Latency: state, SIG and PAT_CNT update 1 cycle after the inputs; G17 is combinational.
// Backpressure: none; SE freezes compaction, MISR_EN gates it, MISR_CLR clears it.
// Ports: CK/RN clock and async active-low reset; G_IN {G3,G2,G1,G0} per channel;
//        G17 per-channel output; SE/SI/SO scan; MISR_EN/MISR_CLR compaction control;
//        SIG signature; PAT_CNT saturating pattern count; STATE {G5,G6,G7} per channel;
//        RARE_CNT rare-state hit count, a live counter only when RARE_MON_EN is defined.
module s27_array_misr #(
    parameter int unsigned       CH         = 4,
    parameter int unsigned       MISR_W     = 16,
    parameter logic [MISR_W-1:0] POLY       = MISR_W'(16'h1021),
    parameter int unsigned       CNT_W      = 16,
    parameter logic [2:0]        RARE_STATE = 3'b101
) (
    input  logic                CK,
    input  logic                RN,
    input  logic [4*CH-1:0]     G_IN,
    output logic [CH-1:0]       G17,
    input  logic                SE,
    input  logic                SI,
    output logic                SO,
    input  logic                MISR_EN,
    input  logic                MISR_CLR,
    output logic [MISR_W-1:0]   SIG,
    output logic [CNT_W-1:0]    PAT_CNT,
    output logic [3*CH-1:0]     STATE,
    output logic [15:0]         RARE_CNT
);

    // Channel c state lives at state_q[3c+2:3c] = {G5,G6,G7}.
    logic [3*CH-1:0]   state_q, state_d;
    logic [3*CH-1:0]   func_nxt;   // {G10,G11,G13} per channel
    logic [3*CH-1:0]   scan_nxt;
    logic [MISR_W-1:0] sig_q, sig_d, misr_t;
    logic [CNT_W-1:0]  pat_q, pat_d;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic g0, g1, g2, g3, g5, g6, g7;
        logic g8, g9, g10, g11, g12, g13, g14, g15, g16;

        assign {g3, g2, g1, g0} = G_IN[4*c +: 4];
        assign {g5, g6, g7}     = state_q[3*c +: 3];

        assign g14 = ~g0;
        assign g8  = g14 & g6;
        assign g12 = ~(g1 | g7);
        assign g15 = g12 | g8;
        assign g16 = g3 | g8;
        assign g9  = ~(g16 & g15);
        assign g11 = ~(g5 | g9);
        assign g10 = ~(g14 | g11);
        assign g13 = ~(g2 | g12);

        assign G17[c]              = ~g11;
        assign func_nxt[3*c +: 3]  = {g10, g11, g13};

        // Chain runs G5 -> G6 -> G7 inside a channel, then G7 of channel c-1
        // feeds G5 of channel c, which is not a plain left shift of state_q.
        if (c == 0) begin : g_head
            assign scan_nxt[2] = SI;
        end else begin : g_link
            assign scan_nxt[3*c+2] = state_q[3*c-3];
        end
        assign scan_nxt[3*c+1] = state_q[3*c+2];
        assign scan_nxt[3*c]   = state_q[3*c+1];
    end

    // Scan takes priority over the functional update.
    assign state_d = SE ? scan_nxt : func_nxt;

    always_comb begin
        misr_t = {sig_q[MISR_W-2:0], 1'b0};
        if (sig_q[MISR_W-1]) begin
            misr_t = misr_t ^ POLY;
        end
        // Channels beyond MISR_W wrap around and share signature bits.
        for (int c = 0; c < int'(CH); c++) begin
            misr_t[c % MISR_W] = misr_t[c % MISR_W] ^ G17[c];
        end
    end

    always_comb begin
        sig_d = sig_q;
        pat_d = pat_q;
        if (MISR_CLR) begin
            sig_d = '0;
            pat_d = '0;
        end else if (!SE && MISR_EN) begin
            sig_d = misr_t;
            if (pat_q != '1) begin
                pat_d = pat_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= '0;
            sig_q   <= '0;
            pat_q   <= '0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            pat_q   <= pat_d;
        end
    end

    assign SO      = state_q[3*(CH-1)];
    assign STATE   = state_q;
    assign SIG     = sig_q;
    assign PAT_CNT = pat_q;

`ifdef RARE_MON_EN
    logic        rare_hit;
    logic [15:0] rare_q, rare_d;

    // Looks at the state being entered, so a hit is counted on the edge
    // that lands a channel in RARE_STATE.
    always_comb begin
        rare_hit = 1'b0;
        for (int c = 0; c < int'(CH); c++) begin
            if (func_nxt[3*c +: 3] == RARE_STATE) begin
                rare_hit = 1'b1;
            end
        end
    end

    always_comb begin
        rare_d = rare_q;
        if (MISR_CLR) begin
            rare_d = '0;
        end else if (!SE && rare_hit && (rare_q != 16'hFFFF)) begin
            rare_d = rare_q + 16'd1;
        end
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            rare_q <= '0;
        end else begin
            rare_q <= rare_d;
        end
    end

    assign RARE_CNT = rare_q;
`else
    assign RARE_CNT = 16'h0000;
`endif

endmodule

// File: tb/tb_s27_array_misr.sv
module tb_s27_array_misr;

`ifdef RARE_MON_EN
    localparam bit RARE_ON = 1'b1;
`else
    localparam bit RARE_ON = 1'b0;
`endif

    logic ck = 1'b0;
    always #5 ck = ~ck;

    // u1: CH=1, 8-bit MISR with POLY 0x1D
    logic        rn1, se1, si1, en1, clr1, so1;
    logic [3:0]  gin1;
    logic [0:0]  g17_1;
    logic [7:0]  sig1;
    logic [15:0] pat1, rare1;
    logic [2:0]  st1;

    // u2: CH=2, default MISR
    logic        rn2, se2, si2, en2, clr2, so2;
    logic [7:0]  gin2;
    logic [1:0]  g17_2;
    logic [15:0] sig2, pat2, rare2;
    logic [5:0]  st2;

    s27_array_misr #(.CH(1), .MISR_W(8), .POLY(8'h1D)) u1 (
        .CK(ck), .RN(rn1), .G_IN(gin1), .G17(g17_1), .SE(se1), .SI(si1), .SO(so1),
        .MISR_EN(en1), .MISR_CLR(clr1), .SIG(sig1), .PAT_CNT(pat1), .STATE(st1),
        .RARE_CNT(rare1)
    );

    s27_array_misr #(.CH(2)) u2 (
        .CK(ck), .RN(rn2), .G_IN(gin2), .G17(g17_2), .SE(se2), .SI(si2), .SO(so2),
        .MISR_EN(en2), .MISR_CLR(clr2), .SIG(sig2), .PAT_CNT(pat2), .STATE(st2),
        .RARE_CNT(rare2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] rare_exp(input logic [15:0] v);
        return RARE_ON ? v : 16'h0000;
    endfunction

    typedef struct {
        logic [3:0]  g;
        logic        en;
        logic        clr;
        logic        g17;   // pre-edge
        logic [2:0]  st;    // post-edge
        logic [7:0]  sig;
        logic [15:0] pat;
        logic [15:0] rare;  // value with the rare monitor built in
    } vec_t;

    vec_t tbl [21];
    logic sin_seq  [6];
    logic sout_seq [6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //              g     en    clr   g17   st      sig    pat     rare
        tbl[0]  = '{4'h0, 1'b0, 1'b0, 1'b1, 3'b000, 8'h00, 16'd0,  16'd0};
        tbl[1]  = '{4'h0, 1'b1, 1'b0, 1'b1, 3'b000, 8'h01, 16'd1,  16'd0};
        tbl[2]  = '{4'h0, 1'b1, 1'b0, 1'b1, 3'b000, 8'h03, 16'd2,  16'd0};
        tbl[3]  = '{4'h0, 1'b1, 1'b0, 1'b1, 3'b000, 8'h07, 16'd3,  16'd0};
        tbl[4]  = '{4'h0, 1'b1, 1'b0, 1'b1, 3'b000, 8'h0F, 16'd4,  16'd0};
        tbl[5]  = '{4'h0, 1'b1, 1'b1, 1'b1, 3'b000, 8'h00, 16'd0,  16'd0};
        tbl[6]  = '{4'h8, 1'b1, 1'b0, 1'b0, 3'b010, 8'h00, 16'd1,  16'd0};
        tbl[7]  = '{4'h0, 1'b1, 1'b0, 1'b0, 3'b010, 8'h00, 16'd2,  16'd0};
        tbl[8]  = '{4'h3, 1'b1, 1'b0, 1'b1, 3'b101, 8'h01, 16'd3,  16'd1};
        tbl[9]  = '{4'h3, 1'b1, 1'b0, 1'b1, 3'b101, 8'h03, 16'd4,  16'd2};
        tbl[10] = '{4'h3, 1'b1, 1'b0, 1'b1, 3'b101, 8'h07, 16'd5,  16'd3};
        tbl[11] = '{4'h3, 1'b1, 1'b0, 1'b1, 3'b101, 8'h0F, 16'd6,  16'd4};
        tbl[12] = '{4'h3, 1'b1, 1'b0, 1'b1, 3'b101, 8'h1F, 16'd7,  16'd5};
        tbl[13] = '{4'h3, 1'b1, 1'b0, 1'b1, 3'b101, 8'h3F, 16'd8,  16'd6};
        tbl[14] = '{4'h3, 1'b1, 1'b0, 1'b1, 3'b101, 8'h7F, 16'd9,  16'd7};
        tbl[15] = '{4'h3, 1'b1, 1'b0, 1'b1, 3'b101, 8'hFF, 16'd10, 16'd8};
        tbl[16] = '{4'h3, 1'b1, 1'b0, 1'b1, 3'b101, 8'hE2, 16'd11, 16'd9};
        tbl[17] = '{4'h3, 1'b1, 1'b0, 1'b1, 3'b101, 8'hD8, 16'd12, 16'd10};
        tbl[18] = '{4'h3, 1'b0, 1'b0, 1'b1, 3'b101, 8'hD8, 16'd12, 16'd11};
        tbl[19] = '{4'h8, 1'b1, 1'b0, 1'b1, 3'b001, 8'hAC, 16'd13, 16'd11};
        tbl[20] = '{4'h0, 1'b1, 1'b0, 1'b1, 3'b001, 8'h44, 16'd14, 16'd11};

        sin_seq  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        sout_seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        rn1 = 1'b0; gin1 = 4'h0; se1 = 1'b0; si1 = 1'b0; en1 = 1'b0; clr1 = 1'b0;
        rn2 = 1'b0; gin2 = 8'h00; se2 = 1'b0; si2 = 1'b0; en2 = 1'b0; clr2 = 1'b0;

        // Reset values
        #1;
        chk("rst_state", 32'(st1), 32'h0);
        chk("rst_sig",   32'(sig1), 32'h0);
        chk("rst_pat",   32'(pat1), 32'h0);
        chk("rst_rare",  32'(rare1), 32'h0);
        chk("rst_so",    32'(so1), 32'h0);
        chk("rst_g17",   32'(g17_1), 32'h1);
        #1;
        rn1 = 1'b1;
        rn2 = 1'b1;

        // G_IN=0 keeps the core in state 0 with G17=1
        for (int i = 0; i < 3; i++) begin
            #1 chk("idle_g17", 32'(g17_1), 32'h1);
            @(posedge ck); #1;
            chk("idle_state", 32'(st1), 32'h0);
        end

        // G_IN=3 lands in 101 and stays there
        gin1 = 4'h3;
        #1 chk("g3_g17", 32'(g17_1), 32'h1);
        @(posedge ck); #1;
        chk("g3_state1", 32'(st1), 32'b101);
        @(posedge ck); #1;
        chk("g3_state2", 32'(st1), 32'b101);
        chk("g3_rare",   32'(rare1), 32'(rare_exp(16'd2)));

        // Fresh start for the table
        rn1 = 1'b0;
        #1;
        chk("rst2_state", 32'(st1), 32'h0);
        chk("rst2_rare",  32'(rare1), 32'h0);
        rn1 = 1'b1;

        for (int i = 0; i < 21; i++) begin
            gin1 = tbl[i].g;
            en1  = tbl[i].en;
            clr1 = tbl[i].clr;
            #1 chk($sformatf("tbl%0d_g17", i), 32'(g17_1), 32'(tbl[i].g17));
            @(posedge ck); #1;
            chk($sformatf("tbl%0d_state", i), 32'(st1), 32'(tbl[i].st));
            chk($sformatf("tbl%0d_sig", i),   32'(sig1), 32'(tbl[i].sig));
            chk($sformatf("tbl%0d_pat", i),   32'(pat1), 32'(tbl[i].pat));
            chk($sformatf("tbl%0d_rare", i),  32'(rare1), 32'(rare_exp(tbl[i].rare)));
        end
        clr1 = 1'b0;

        // Async reset in the middle of compaction
        gin1 = 4'h3;
        en1  = 1'b1;
        @(posedge ck); #3;
        rn1 = 1'b0;
        #1;
        chk("midcmp_state", 32'(st1), 32'h0);
        chk("midcmp_sig",   32'(sig1), 32'h0);
        chk("midcmp_pat",   32'(pat1), 32'h0);
        chk("midcmp_rare",  32'(rare1), 32'h0);
        rn1 = 1'b1;

        // u2: one compaction so the signature is nonzero before scanning
        en2 = 1'b1;
        #1 chk("u2_g17", 32'(g17_2), 32'b11);
        @(posedge ck); #1;
        chk("u2_sig0", 32'(sig2), 32'h0003);
        chk("u2_pat0", 32'(pat2), 32'd1);

        // Shift in 1,0,1,1,0,1 with MISR_EN still high
        se2 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            si2 = sin_seq[i];
            #1 chk($sformatf("scan_in%0d_so", i), 32'(so2), 32'h0);
            @(posedge ck); #1;
        end
        chk("scan_state", 32'(st2), 32'b101101);
        chk("scan_sig",   32'(sig2), 32'h0003);
        chk("scan_pat",   32'(pat2), 32'd1);
        chk("scan_rare",  32'(rare2), 32'h0);

        si2 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1 chk($sformatf("scan_out%0d_so", i), 32'(so2), 32'(sout_seq[i]));
            @(posedge ck); #1;
        end
        chk("scan_empty", 32'(st2), 32'h0);
        chk("scan_sig2",  32'(sig2), 32'h0003);

        // Async reset in the middle of a shift
        si2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge ck); #1;
        end
        chk("midshift_pre", 32'(st2), 32'b000111);
        #2;
        rn2 = 1'b0;
        #1;
        chk("midshift_state", 32'(st2), 32'h0);
        chk("midshift_sig",   32'(sig2), 32'h0);
        chk("midshift_pat",   32'(pat2), 32'h0);
        chk("midshift_rare",  32'(rare2), 32'h0);
        chk("midshift_so",    32'(so2), 32'h0);
        rn2 = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
